// File: rtl/alu_issue_ctrl_if.sv
// Command, response and ALU drive signals of the issue controller, bundled.
// The controller uses the slave modport; the issuing side and ALU use master.
interface alu_issue_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_a;
    logic [1:0] cmd_b;
    logic [1:0] cmd_op;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_y;
    logic       rsp_c;
    logic       rsp_timeout;

    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_ctrl;
    logic       alu_done;
    logic [3:0] alu_y;
    logic       alu_c;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_y, alu_c,
        output cmd_ready, rsp_valid, rsp_y, rsp_c, rsp_timeout, alu_a, alu_b, alu_ctrl
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_op, rsp_ready, alu_done, alu_y, alu_c,
        input  cmd_ready, rsp_valid, rsp_y, rsp_c, rsp_timeout, alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the multicycle ALU: queues commands, drives operands,
// waits for a clean done handshake and returns the result or a timeout.
//
// state | meaning
// IDLE  | waiting for a queued command; pops and drives it onto the ALU
// ARM   | discarding the first done, which may belong to stale operands
// WAIT  | next done captures the result
// RESP  | response held until the consumer accepts it
module alu_issue_ctrl #(
    parameter int CMD_DEPTH = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic             clk,
    input  logic             reset,
    alu_issue_ctrl_if.slave  bus,
    output logic             busy,
    output logic [7:0]       op_count
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, WAIT, RESP} state_t;

    logic [5:0]    mem [CMD_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    state_t        state;
    logic [TW-1:0] timer;

    assign full          = (count == (AW+1)'(CMD_DEPTH));
    assign empty         = (count == '0);
    assign bus.cmd_ready = !reset && !full;
    assign push          = bus.cmd_valid && bus.cmd_ready;
    assign pop           = (state == IDLE) && !empty;
    assign busy          = !reset && ((state != IDLE) || !empty);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.cmd_op, bus.cmd_a, bus.cmd_b};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Timer is a down-counter loaded at issue; reaching zero in ARM/WAIT
    // marks TIMEOUT edges since the pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            timer           <= '0;
            bus.alu_a       <= '0;
            bus.alu_b       <= '0;
            bus.alu_ctrl    <= '0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_y       <= '0;
            bus.rsp_c       <= 1'b0;
            bus.rsp_timeout <= 1'b0;
            op_count        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!empty) begin
                        {bus.alu_ctrl, bus.alu_a, bus.alu_b} <= mem[rd_ptr];
                        timer <= TIMER_LOAD;
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (timer == '0) begin
                        bus.rsp_y       <= '0;
                        bus.rsp_c       <= 1'b0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        timer <= timer - 1'b1;
                        if (bus.alu_done) begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A done on the terminal edge still counts as a capture.
                    if (bus.alu_done) begin
                        bus.rsp_y       <= bus.alu_y;
                        bus.rsp_c       <= bus.alu_c;
                        bus.rsp_timeout <= 1'b0;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else if (timer == '0) begin
                        bus.rsp_y       <= '0;
                        bus.rsp_c       <= 1'b0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        state           <= RESP;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        op_count      <= op_count + 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural 3-cycle ALU attached.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] op_count;
    logic       busy;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    int         exp_cnt = 0;

    alu_issue_ctrl_if intf();

    alu_issue_ctrl #(.CMD_DEPTH(4), .TIMEOUT(15)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (intf),
        .busy     (busy),
        .op_count (op_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU stand-in: free-running 3-phase loop, operands latched at loop start,
    // done raised in the third cycle.
    logic [1:0] ph = 2'd0;
    logic [3:0] au_y = 4'd0;
    logic       au_c = 1'b0;
    logic       tie_done = 1'b0;

    function automatic logic [4:0] au_calc(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] op);
        logic [4:0] r;
        case (op)
            2'b00:   r = {3'b000, a} + {3'b000, b};
            2'b01:   r = {3'b000, a} - {3'b000, b};
            2'b10:   r = {1'b0, 2'b00, a} * {1'b0, 2'b00, b};
            default: r = (b == 2'd0) ? 5'b10000 : {3'b000, a / b};
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        ph <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
        if (ph == 2'd0) {au_c, au_y} <= au_calc(intf.alu_a, intf.alu_b, intf.alu_ctrl);
    end
    assign intf.alu_done = (ph == 2'd2) && !tie_done;
    assign intf.alu_y    = au_y;
    assign intf.alu_c    = au_c;

    typedef struct {
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] op;
        int         y;
        int         c;
    } vec_t;

    vec_t vecs[8];
    vec_t bp[6];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [1:0] a, input logic [1:0] b, input logic [1:0] op,
                            output int acc_edge);
        int k = 0;
        intf.cmd_a = a; intf.cmd_b = b; intf.cmd_op = op; intf.cmd_valid = 1'b1;
        while (!intf.cmd_ready && k < 20) begin tick(); k++; end
        if (k == 20) chk("push_wait", 0, 1);
        tick();
        acc_edge = cyc;
        intf.cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int edge_n);
        int k = 0;
        while (!intf.rsp_valid && k < 40) begin tick(); k++; end
        if (k == 40) chk("rsp_wait", 0, 1);
        edge_n = cyc;
    endtask

    task automatic handshake();
        intf.rsp_ready = 1'b1;
        tick();
        intf.rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 1) % 256;
        chk("hs_valid_clear", int'(intf.rsp_valid), 0);
        chk("hs_op_count", int'(op_count), exp_cnt);
    endtask

    initial begin
        int acc, pop_e, rsp_e, idx, k, got, n;
        logic rdy, pend, saw_ready, seen;
        int exp_y[6];
        int exp_c[6];

        vecs[0] = '{2'd3, 2'd2, 2'b00, 5, 0};
        vecs[1] = '{2'd2, 2'd0, 2'b11, 0, 1};
        vecs[2] = '{2'd1, 2'd2, 2'b01, 15, 1};
        vecs[3] = '{2'd3, 2'd3, 2'b10, 9, 0};
        vecs[4] = '{2'd3, 2'd1, 2'b11, 3, 0};
        vecs[5] = '{2'd3, 2'd2, 2'b10, 6, 0};
        vecs[6] = '{2'd3, 2'd3, 2'b00, 6, 0};
        vecs[7] = '{2'd2, 2'd1, 2'b01, 1, 0};

        bp[0] = '{2'd3, 2'd3, 2'b10, 9, 0};
        bp[1] = '{2'd1, 2'd2, 2'b01, 15, 1};
        bp[2] = '{2'd3, 2'd1, 2'b11, 3, 0};
        bp[3] = '{2'd2, 2'd2, 2'b00, 4, 0};
        bp[4] = '{2'd0, 2'd1, 2'b01, 15, 1};
        bp[5] = '{2'd1, 2'd1, 2'b00, 2, 0};

        intf.cmd_valid = 1'b0; intf.cmd_a = '0; intf.cmd_b = '0; intf.cmd_op = '0;
        intf.rsp_ready = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_cmd_ready", int'(intf.cmd_ready), 0);
        chk("rst_rsp_valid", int'(intf.rsp_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_op_count", int'(op_count), 0);
        chk("rst_alu_drive", int'({intf.alu_ctrl, intf.alu_a, intf.alu_b}), 0);
        reset = 1'b0;
        tick();
        chk("post_rst_cmd_ready", int'(intf.cmd_ready), 1);

        // Single commands from the table
        for (int i = 0; i < 8; i++) begin
            push_one(vecs[i].a, vecs[i].b, vecs[i].op, acc);
            tick();
            pop_e = cyc;
            chk("issue_drive", int'({intf.alu_ctrl, intf.alu_a, intf.alu_b}),
                int'({vecs[i].op, vecs[i].a, vecs[i].b}));
            chk("issue_busy", int'(busy), 1);
            wait_rsp(rsp_e);
            chk("rsp_latency_4_6", int'((rsp_e - pop_e) >= 4 && (rsp_e - pop_e) <= 6), 1);
            chk("rsp_y", int'(intf.rsp_y), vecs[i].y);
            chk("rsp_c", int'(intf.rsp_c), vecs[i].c);
            chk("rsp_timeout", int'(intf.rsp_timeout), 0);
            handshake();
            chk("idle_busy", int'(busy), 0);
        end

        // Backpressure: five fit (one in flight plus four queued)
        for (int i = 0; i < 6; i++) begin exp_y[i] = bp[i].y; exp_c[i] = bp[i].c; end
        idx = 0; k = 0;
        intf.cmd_a = bp[0].a; intf.cmd_b = bp[0].b; intf.cmd_op = bp[0].op;
        intf.cmd_valid = 1'b1;
        while (idx < 6 && k < 12) begin
            rdy = intf.cmd_ready;
            tick(); k++;
            if (rdy) begin
                idx++;
                if (idx < 6) begin
                    intf.cmd_a = bp[idx].a; intf.cmd_b = bp[idx].b; intf.cmd_op = bp[idx].op;
                end
            end
        end
        chk("bp_accepted", idx, 5);
        chk("bp_cmd_ready_low", int'(intf.cmd_ready), 0);
        chk("bp_hold_valid", int'(intf.rsp_valid), 1);
        chk("bp_hold_y0", int'(intf.rsp_y), 9);
        tick(); tick();
        chk("bp_hold_y1", int'(intf.rsp_y), 9);

        intf.rsp_ready = 1'b1;
        got = 0; k = 0; saw_ready = 1'b0;
        while (got < 6 && k < 200) begin
            rdy = intf.cmd_ready;
            if (rdy) saw_ready = 1'b1;
            if (intf.rsp_valid) begin
                chk("bp_order_y", int'(intf.rsp_y), exp_y[got]);
                chk("bp_order_c", int'(intf.rsp_c), exp_c[got]);
                got++;
            end
            tick(); k++;
            if (rdy && idx == 5) begin idx = 6; intf.cmd_valid = 1'b0; end
        end
        intf.rsp_ready = 1'b0;
        exp_cnt = (exp_cnt + 6) % 256;
        chk("bp_responses", got, 6);
        chk("bp_ready_returned", int'(saw_ready), 1);
        chk("bp_op_count", int'(op_count), exp_cnt);
        chk("bp_cmd_ready_end", int'(intf.cmd_ready), 1);

        // Timeout with done held low
        tie_done = 1'b1;
        push_one(2'd2, 2'd1, 2'b00, acc);
        tick();
        pop_e = cyc;
        wait_rsp(rsp_e);
        chk("to_edge", rsp_e - pop_e, 15);
        chk("to_flag", int'(intf.rsp_timeout), 1);
        chk("to_y", int'(intf.rsp_y), 0);
        chk("to_c", int'(intf.rsp_c), 0);
        tick(); tick(); tick();
        chk("to_hold_valid", int'(intf.rsp_valid), 1);
        chk("to_hold_busy", int'(busy), 1);
        handshake();
        chk("to_busy_clear", int'(busy), 0);
        tie_done = 1'b0;

        // Reset while WAIT with two commands queued
        for (int i = 0; i < 3; i++) begin
            intf.cmd_a = 2'd1; intf.cmd_b = 2'd1; intf.cmd_op = 2'b00; intf.cmd_valid = 1'b1;
            tick();
            if (i == 0) acc = cyc;
        end
        intf.cmd_valid = 1'b0;
        while (cyc < acc + 4) tick();
        reset = 1'b1;
        tick();
        chk("mid_rst_rsp_valid", int'(intf.rsp_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cmd_ready", int'(intf.cmd_ready), 0);
        chk("mid_rst_op_count", int'(op_count), 0);
        chk("mid_rst_alu_drive", int'({intf.alu_ctrl, intf.alu_a, intf.alu_b}), 0);
        tick();
        reset = 1'b0;
        exp_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (intf.rsp_valid || busy) seen = 1'b1;
        end
        chk("mid_rst_no_rsp", int'(seen), 0);
        push_one(2'd1, 2'd2, 2'b10, acc);
        wait_rsp(rsp_e);
        chk("post_rst_y", int'(intf.rsp_y), 2);
        chk("post_rst_c", int'(intf.rsp_c), 0);
        handshake();

        // op_count wrap over 256 handshakes
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        intf.cmd_a = 2'd1; intf.cmd_b = 2'd1; intf.cmd_op = 2'b00; intf.cmd_valid = 1'b1;
        intf.rsp_ready = 1'b1;
        n = 0; k = 0;
        while (n < 256 && k < 4000) begin
            pend = intf.rsp_valid;
            tick(); k++;
            if (pend) begin
                n++;
                if (n == 1)   chk("wrap_first", int'(op_count), 1);
                if (n == 255) chk("wrap_255", int'(op_count), 255);
                if (n == 256) chk("wrap_zero", int'(op_count), 0);
            end
        end
        chk("wrap_ops", n, 256);
        intf.cmd_valid = 1'b0;
        intf.rsp_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1);
    end
endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Command-side initiator for the multicycle ALU (`au`). It accepts operation requests over a valid/ready command port and buffers them in a small FIFO. It drives each operand set onto the ALU's `a`/`b`/`ctrl` inputs, waits for a clean `done` handshake, captures `y`/`c`, and returns the result over a valid/ready response port. It sits between the issuing logic and a free-running `au` instance, and flags a response as timed out if `done` never arrives.

## Interface
- `CMD_DEPTH`, 4: command FIFO entries; power of two, at least 2.
- `TIMEOUT`, 15: clock edges after issue before a missing result is declared a timeout; at least 8.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted this cycle when high together with `cmd_valid`.
- `cmd_a`, `cmd_b`  in  2 each  operands.
- `cmd_op`  in  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
- `rsp_valid`  out  1  response held valid.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_y`  out  4  captured ALU result.
- `rsp_c`  out  1  captured carry/borrow/div-by-zero flag.
- `rsp_timeout`  out  1  response produced by timeout, not by ALU.
- `alu_a`, `alu_b`, `alu_ctrl`  out  2 each  registered drive to the ALU.
- `alu_done`  in  1  ALU done pulse; `au` runs a fixed 3-cycle loop and raises it in every third cycle.
- `alu_y`  in  4  ALU result.
- `alu_c`  in  1  ALU flag.
- `busy`  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
- `op_count`  out  8  count of accepted responses; wraps from 255 to 0.

## Operation
- **FIFO.** 6-bit entries `{op,a,b}` with wrap-around read/write pointers and an occupancy count.
  - `cmd_ready = !full`.
  - Push on `cmd_valid && cmd_ready`. A push and pop in the same cycle leave the count unchanged.
- **FSM states:** IDLE, ARM, WAIT, RESP.
- **IDLE.** If the FIFO is non-empty, pop the head, register it onto `alu_a`/`alu_b`/`alu_ctrl`, clear the timer, and go to ARM.
- **ARM.** `au` may already be mid-loop with stale operands. The first sampled `alu_done` is discarded and moves the FSM to WAIT.
- **WAIT.** On the next sampled `alu_done`, capture `alu_y`→`rsp_y` and `alu_c`→`rsp_c`, set `rsp_valid=1` and `rsp_timeout=0`, and go to RESP.
- **Timer.** Increments on every edge spent in ARM or WAIT. If it reaches `TIMEOUT` without a capture, set `rsp_y=0`, `rsp_c=0`, `rsp_timeout=1`, `rsp_valid=1`, and go to RESP. If capture and timeout coincide on the same edge, capture wins.
- **RESP.** `rsp_*` are held stable while `rsp_valid && !rsp_ready`. On `rsp_valid && rsp_ready`:
  - clear `rsp_valid`,
  - increment `op_count` (timeouts included),
  - go to IDLE.
- **Drive hold.** `alu_a`/`alu_b`/`alu_ctrl` hold their last values until the next pop.
- **Result format.** Results pass through unmodified. Sub borrow follows `au` 5-bit semantics (1−2 → y=15, c=1). Div by zero → y=0, c=1.

## Timing
- **Reset.** All outputs are 0 while `reset` is high, including `cmd_ready`, and FIFO writes are blocked. From the first cycle after reset, `cmd_ready=1`.
  - Reset clears: FIFO, FSM (to IDLE), timer, `rsp_*`, `alu_*`, `op_count`, `busy`.
- **Reset mid-operation** (any state, queued or in-flight ops): all work is dropped and no response is produced.
- **Issue latency.** Command accepted at edge N into an empty FIFO with the FSM in IDLE → popped at edge N+1.
- **Result latency.** With `au` attached, `rsp_valid` rises 4–6 edges after the pop edge.
- **Next command.** The earliest next pop is the edge after the response handshake (one IDLE cycle).
- **Full FIFO.** With the FIFO full, `cmd_ready` is low in that same cycle; a command held on the port is not lost.

## Test plan
- **Add.** Reset, then cmd a=3, b=2, op=00 with `au` attached → `rsp_y=5`, `rsp_c=0`, `rsp_timeout=0`, `rsp_valid` rising 4–6 edges after the pop; `op_count=1`.
- **Divide by zero.** cmd a=2, b=0, op=11 → `rsp_y=0`, `rsp_c=1`.
- **Backpressure and ordering.** `rsp_ready=0`, offer 6 cmds back-to-back: (3,3,mul), (1,2,sub), (3,1,div), (2,2,add), (0,1,sub), (1,1,add).
  - Exactly 5 are accepted, then `cmd_ready=0`.
  - Raise `rsp_ready`: responses arrive in order — 9/0, 15/1, 3/0, 4/0, 15/1 — and `cmd_ready` returns to 1.
- **Timeout.** Tie `alu_done=0`, issue one cmd → `rsp_valid=1`, `rsp_timeout=1`, `rsp_y=0`, `rsp_c=0` at edge 15 after the pop. `busy` stays 1 until the handshake.
- **Reset mid-operation.** Assert `reset` during WAIT with 2 cmds queued → no response ever appears; `busy=0`, `op_count=0`, `alu_a/b/ctrl=0`; a new cmd after reset completes normally.
- **Counter wrap.** Run 256 ops → `op_count` goes 255 → 0 on the 256th handshake.
